// File: rtl/bd_pkg.sv
// Shared definitions for the BD (buffer-descriptor) datapath blocks.
//
// Contents:
//   BD_WORD_BITS  - width of a full BD word from the word source
//   BD_CHUNK_BITS - width of one chunk on the narrow BD link
//   ser_state_t   - serializer state (EMPTY: nothing to emit, SHIFT: emitting)
//   bd_word_t     - convenience type for a full BD word
package bd_pkg;

    localparam int unsigned BD_WORD_BITS  = 32;
    localparam int unsigned BD_CHUNK_BITS = 8;

    typedef enum logic {
        SER_EMPTY,
        SER_SHIFT
    } ser_state_t;

    typedef logic [BD_WORD_BITS-1:0] bd_word_t;

endpackage

// File: rtl/bd_skid_reg.sv
// One-entry ready/valid holding register.
//
// Holds a single word that arrived while the consumer was busy. The ready
// output is a pure register: it reflects "not full" as of the next edge, so
// an upstream source never sees a combinational path through this block.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (clears the full flag only)
//   load_i  - capture data_i this cycle (caller guarantees the entry is free)
//   data_i  - word to capture
//   pop_i   - the held word is consumed this cycle
//   data_o  - held word
//   full_o  - entry holds a valid word
//   ready_o - registered !full, low while reset is asserted
module bd_skid_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         ready_o
);

    logic [W-1:0] buf_q;
    logic         full_q, full_d;
    logic         ready_q;

    always_comb begin
        full_d = full_q;
        if (pop_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            full_q  <= full_d;
            // Computed from next-state so ready tracks full with no lag.
            ready_q <= !full_d;
        end
    end

    // Data needs no reset: it is only observed while full_q is set.
    always_ff @(posedge clk) begin
        if (load_i) begin
            buf_q <= data_i;
        end
    end

    assign data_o  = buf_q;
    assign full_o  = full_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/bd_word_serializer.sv
// Word-to-chunk serializer between a wide BD word source and a narrow BD link.
//
// Each accepted IN_BITS word is emitted as IN_BITS/OUT_BITS chunks, MSB chunk
// first when MSB_FIRST=1, else LSB chunk first. out_last marks the final
// chunk of each word. A one-entry holding register lets the next word be
// accepted while the current one is still shifting, so words stream with no
// bubble and in_ready is a flop output.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   in_data   - input word
//   in_valid  - input word present
//   in_ready  - stage can accept a word (registered)
//   out_data  - current chunk (0 while no chunk is presented)
//   out_valid - chunk present
//   out_last  - chunk is the final chunk of its word
//   out_ready - downstream accepts the chunk
module bd_word_serializer
    import bd_pkg::*;
#(
    parameter int unsigned IN_BITS   = BD_WORD_BITS,
    parameter int unsigned OUT_BITS  = BD_CHUNK_BITS,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_BITS-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready
);

    localparam int unsigned   NCHUNK   = IN_BITS / OUT_BITS;
    localparam int unsigned   CW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    generate
        if ((IN_BITS % OUT_BITS) != 0 || NCHUNK < 2) begin : g_bad_params
            $fatal(1, "bd_word_serializer: IN_BITS must be a multiple of OUT_BITS with at least 2 chunks");
        end
    endgenerate

    ser_state_t          state_q, state_d;
    logic [IN_BITS-1:0]  sh_q, sh_d;
    logic [IN_BITS-1:0]  sh_shifted;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OUT_BITS-1:0] chunk;

    logic [IN_BITS-1:0]  buf_data;
    logic                buf_full;
    logic                buf_load;
    logic                buf_pop;

    logic                in_xfer;
    logic                out_xfer;
    logic                on_last;

    // The emit end of the shift register depends on chunk order.
    generate
        if (MSB_FIRST) begin : g_msb
            assign chunk      = sh_q[IN_BITS-1 -: OUT_BITS];
            assign sh_shifted = sh_q << OUT_BITS;
        end else begin : g_lsb
            assign chunk      = sh_q[OUT_BITS-1:0];
            assign sh_shifted = sh_q >> OUT_BITS;
        end
    endgenerate

    assign out_valid = (state_q == SER_SHIFT);
    assign on_last   = (cnt_q == LAST_CNT);
    assign out_last  = out_valid && on_last;
    // Gated so the bus reads 0 whenever nothing is presented, including reset.
    assign out_data  = out_valid ? chunk : '0;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    bd_skid_reg #(
        .W (IN_BITS)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (buf_load),
        .data_i  (in_data),
        .pop_i   (buf_pop),
        .data_o  (buf_data),
        .full_o  (buf_full),
        .ready_o (in_ready)
    );

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        buf_load = 1'b0;
        buf_pop  = 1'b0;

        case (state_q)
            SER_EMPTY: begin
                // The holding register is always empty here, so load directly.
                if (in_xfer) begin
                    sh_d    = in_data;
                    cnt_d   = '0;
                    state_d = SER_SHIFT;
                end
            end

            SER_SHIFT: begin
                if (out_xfer && !on_last) begin
                    sh_d     = sh_shifted;
                    cnt_d    = cnt_q + CW'(1);
                    buf_load = in_xfer;
                end else if (out_xfer) begin
                    // Last chunk leaves: refill from the held word first,
                    // else let a same-cycle input bypass the holding register.
                    // in_ready is low while buf_full, so both cannot happen.
                    if (buf_full) begin
                        sh_d    = buf_data;
                        cnt_d   = '0;
                        buf_pop = 1'b1;
                    end else if (in_xfer) begin
                        sh_d  = in_data;
                        cnt_d = '0;
                    end else begin
                        state_d = SER_EMPTY;
                    end
                end else begin
                    buf_load = in_xfer;
                end
            end

            default: begin
                state_d = SER_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SER_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

endmodule

// File: tb/tb_bd_word_serializer.sv
module tb_bd_word_serializer;

    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int NCH   = IN_W / OUT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             out_ready;

    logic             in_ready_m, in_ready_l;
    logic [OUT_W-1:0] out_data_m, out_data_l;
    logic             out_valid_m, out_valid_l;
    logic             out_last_m, out_last_l;

    always #5 clk = ~clk;

    bd_word_serializer #(.IN_BITS(IN_W), .OUT_BITS(OUT_W), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .out_data  (out_data_m),
        .out_valid (out_valid_m),
        .out_last  (out_last_m),
        .out_ready (out_ready)
    );

    bd_word_serializer #(.IN_BITS(IN_W), .OUT_BITS(OUT_W), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .out_data  (out_data_l),
        .out_valid (out_valid_l),
        .out_last  (out_last_l),
        .out_ready (out_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // Chunk i of word w in emission order, from plain arithmetic.
    function automatic logic [OUT_W-1:0] chunk_of(input logic [IN_W-1:0] w, input int i, input bit msb);
        int sh;
        logic [IN_W-1:0] t;
        sh = msb ? OUT_W * (NCH - 1 - i) : OUT_W * i;
        t  = w >> sh;
        return t[OUT_W-1:0];
    endfunction

    // ---------------- behavioural model: words held + chunk index ----------
    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
        int               tag;
    } ev_t;

    logic [IN_W-1:0] held_q[$];
    int              idx = 0;
    int              cyc = 0;
    int              acc_cnt = 0;
    int              acc_tag = 0;
    int              words_done = 0;
    int              zrun = 0;
    int              zmax = 0;
    logic            rdy_ok = 1'b0;
    ev_t             lm[$];
    ev_t             ll[$];

    bit               prev_stall = 0;
    logic [OUT_W-1:0] prev_dm, prev_dl;
    logic             prev_lm, prev_ll;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) rdy_ok <= 1'b0;
        else        rdy_ok <= 1'b1;
    end

    always @(negedge clk) begin : compare
        bit exp_v, exp_r, exp_l, in_x, out_x;
        if (!reset) begin
            held_q.delete();
            idx = 0;
            prev_stall = 0;
            zrun = 0;
            check("rst_out_valid_m", {31'd0, out_valid_m}, 32'd0);
            check("rst_out_valid_l", {31'd0, out_valid_l}, 32'd0);
            check("rst_out_last_m", {31'd0, out_last_m}, 32'd0);
            check("rst_in_ready_m", {31'd0, in_ready_m}, 32'd0);
            check("rst_in_ready_l", {31'd0, in_ready_l}, 32'd0);
            check("rst_out_data_m", {24'd0, out_data_m}, 32'd0);
            check("rst_out_data_l", {24'd0, out_data_l}, 32'd0);
        end else begin
            exp_v = (held_q.size() > 0);
            exp_r = rdy_ok && (held_q.size() < 2);
            exp_l = exp_v && (idx == NCH - 1);
            check("out_valid_m", {31'd0, out_valid_m}, {31'd0, exp_v});
            check("out_valid_l", {31'd0, out_valid_l}, {31'd0, exp_v});
            check("in_ready_m", {31'd0, in_ready_m}, {31'd0, exp_r});
            check("in_ready_l", {31'd0, in_ready_l}, {31'd0, exp_r});
            check("out_last_m", {31'd0, out_last_m}, {31'd0, exp_l});
            check("out_last_l", {31'd0, out_last_l}, {31'd0, exp_l});
            if (exp_v) begin
                check("out_data_m", {24'd0, out_data_m}, {24'd0, chunk_of(held_q[0], idx, 1'b1)});
                check("out_data_l", {24'd0, out_data_l}, {24'd0, chunk_of(held_q[0], idx, 1'b0)});
                if (prev_stall) begin
                    check("stall_data_m", {24'd0, out_data_m}, {24'd0, prev_dm});
                    check("stall_data_l", {24'd0, out_data_l}, {24'd0, prev_dl});
                    check("stall_last_m", {31'd0, out_last_m}, {31'd0, prev_lm});
                    check("stall_last_l", {31'd0, out_last_l}, {31'd0, prev_ll});
                end
            end
            if (!exp_r) begin
                zrun++;
                if (zrun > zmax) zmax = zrun;
            end else begin
                zrun = 0;
            end

            in_x  = in_valid && exp_r;
            out_x = exp_v && out_ready;
            if (out_x) begin
                lm.push_back('{d: out_data_m, l: out_last_m, tag: cyc});
                ll.push_back('{d: out_data_l, l: out_last_l, tag: cyc});
                if (idx == NCH - 1) begin
                    void'(held_q.pop_front());
                    idx = 0;
                    words_done++;
                end else begin
                    idx++;
                end
            end
            if (in_x) begin
                held_q.push_back(in_data);
                acc_cnt++;
                acc_tag = cyc;
            end
            prev_stall = exp_v && !out_ready;
            prev_dm = out_data_m;
            prev_dl = out_data_l;
            prev_lm = out_last_m;
            prev_ll = out_last_l;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [IN_W-1:0] w, input bit keep);
        int start;
        bit ok;
        start = acc_cnt;
        ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (acc_cnt != start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("send_accept");
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (held_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("drain");
    endtask

    task automatic clear_logs();
        lm.delete();
        ll.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready_m", {31'd0, in_ready_m}, 32'd1);
        check("post_reset_in_ready_l", {31'd0, in_ready_l}, 32'd1);
    endtask

    bit stop4 = 0;
    int done_before;
    int acc33_tag;
    logic [7:0] exp8;
    logic [31:0] base;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_in_ready", {31'd0, in_ready_m}, 32'd0);
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", {31'd0, in_ready_m}, 32'd1);

        // Single word, both chunk orders.
        clear_logs();
        out_ready = 1'b1;
        send(32'hA1B2C3D4, 0);
        wait_drain(50);
        check("t1_count", lm.size(), 4);
        if (lm.size() == 4) begin
            check("t1_first_latency", lm[0].tag, acc_tag + 1);
            check("t1_m0", {24'd0, lm[0].d}, 32'hA1);
            check("t1_m1", {24'd0, lm[1].d}, 32'hB2);
            check("t1_m2", {24'd0, lm[2].d}, 32'hC3);
            check("t1_m3", {24'd0, lm[3].d}, 32'hD4);
            check("t1_l0", {24'd0, ll[0].d}, 32'hD4);
            check("t1_l1", {24'd0, ll[1].d}, 32'hC3);
            check("t1_l2", {24'd0, ll[2].d}, 32'hB2);
            check("t1_l3", {24'd0, ll[3].d}, 32'hA1);
            for (int i = 0; i < 4; i++) begin
                check("t1_last", {31'd0, lm[i].l}, (i == 3) ? 32'd1 : 32'd0);
                check("t1_consec", lm[i].tag, lm[0].tag + i);
            end
        end

        // Back-to-back words 1,2,3.
        clear_logs();
        zmax = 0;
        send(32'd1, 1);
        send(32'd2, 1);
        send(32'd3, 0);
        wait_drain(50);
        check("t3_count", lm.size(), 12);
        check("t3_in_ready_low_run_le3", (zmax <= 3) ? 32'd1 : 32'd0, 32'd1);
        if (lm.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                exp8 = (i % 4 == 3) ? 8'(i / 4 + 1) : 8'h00;
                check("t3_data_m", {24'd0, lm[i].d}, {24'd0, exp8});
                exp8 = (i % 4 == 0) ? 8'(i / 4 + 1) : 8'h00;
                check("t3_data_l", {24'd0, ll[i].d}, {24'd0, exp8});
                check("t3_no_gap", lm[i].tag, lm[0].tag + i);
            end
        end

        // Holding register fills while the output stalls.
        clear_logs();
        out_ready = 1'b0;
        send(32'h11111111, 0);
        send(32'h22222222, 0);
        in_valid = 1'b1;
        in_data  = 32'h33333333;
        repeat (5) @(posedge clk);
        #1;
        check("t5_in_ready_full", {31'd0, in_ready_m}, 32'd0);
        check("t5_held_chunk", {24'd0, out_data_m}, 32'h11);
        check("t5_accepted", acc_cnt >= 0 ? held_q.size() : 0, 2);
        out_ready = 1'b1;
        send(32'h33333333, 0);
        acc33_tag = acc_tag;
        wait_drain(60);
        check("t5_count", lm.size(), 12);
        if (lm.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                exp8 = (i < 4) ? 8'h11 : (i < 8) ? 8'h22 : 8'h33;
                check("t5_data", {24'd0, lm[i].d}, {24'd0, exp8});
            end
            check("t5_third_after_first", (acc33_tag > lm[3].tag) ? 32'd1 : 32'd0, 32'd1);
        end

        // Asynchronous reset in the middle of a word.
        clear_logs();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        begin : wait_two
            bit ok;
            ok = 0;
            for (int k = 0; k < 50; k++) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                if (lm.size() >= 2) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) fail_now("t6_two_chunks");
        end
        #1 reset = 1'b0;
        #1;
        check("t6_async_out_valid_m", {31'd0, out_valid_m}, 32'd0);
        check("t6_async_out_valid_l", {31'd0, out_valid_l}, 32'd0);
        check("t6_async_in_ready", {31'd0, in_ready_m}, 32'd0);
        check("t6_async_out_data", {24'd0, out_data_m}, 32'd0);
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("t6_release_in_ready", {31'd0, in_ready_m}, 32'd1);
        clear_logs();
        send(32'h01020304, 0);
        wait_drain(50);
        check("t6_count", lm.size(), 4);
        if (lm.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t6_data", {24'd0, lm[i].d}, i + 1);
            end
        end

        // Random valid/ready traffic, 1000 incrementing words.
        done_before = words_done;
        base = $urandom;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(base + i, 0);
                end
                wait_drain(200);
                stop4 = 1;
            end
            begin
                while (!stop4) begin
                    out_ready = 1'b1;
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b0;
                    repeat ($urandom_range(0, 5)) begin
                        @(posedge clk); #1;
                    end
                end
            end
        join
        out_ready = 1'b1;
        check("t4_words_done", words_done - done_before, 1000);

        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bd_word_serializer.md
Name: bd_word_serializer

Overview:
- Ready-valid stage that sits directly downstream of a 32-bit BD word source and feeds a narrower BD link sink.
- Accepts full-width words and emits each one as IN_BITS/OUT_BITS consecutive chunks, with an end-of-word flag on the final chunk.
- Includes a one-entry input buffer, so in_ready is a pure register output and back-to-back words stream with no bubble.

Parameters:
- IN_BITS, 32, width of the input word.
- OUT_BITS, 8, width of the output chunk. IN_BITS must be a multiple of OUT_BITS, and IN_BITS/OUT_BITS must be >= 2.
- MSB_FIRST, 1, 1 = emit the most-significant chunk first; 0 = emit the least-significant chunk first.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  IN_BITS  input word.
- in_valid  in  1  input word is present.
- in_ready  out  1  stage can accept a word (registered).
- out_data  out  OUT_BITS  current chunk.
- out_valid  out  1  chunk is present.
- out_last  out  1  current chunk is the final chunk of its word.
- out_ready  in  1  downstream accepts the chunk.

Behaviour:
- Definitions: NCHUNK = IN_BITS/OUT_BITS; CW = $clog2(NCHUNK). A transfer occurs on a rising clk edge when valid && ready.
- Storage:
  - shift register sh[IN_BITS].
  - chunk counter cnt[CW].
  - input buffer buf[IN_BITS] with flag buf_full.
  - state in {EMPTY, SHIFT}.
- Reset (reset low, asynchronous):
  - state = EMPTY, cnt = 0, buf_full = 0.
  - Outputs: out_valid = 0, out_last = 0, in_ready = 0 while reset is asserted, then in_ready = 1 on the first edge after release.
  - Data registers are don't-care; out_data is driven 0.
  - A word in progress or in the buffer is discarded with no partial replay.
- Output decode:
  - out_valid = (state == SHIFT).
  - out_data = top OUT_BITS of sh when MSB_FIRST, else bottom OUT_BITS.
  - out_last = out_valid && (cnt == NCHUNK-1).
  - out_data and out_last must hold stable while out_valid && !out_ready.
- Input side: in_ready = !buf_full.
- EMPTY state:
  - On an input transfer, load sh = in_data, cnt = 0, and go to SHIFT. Latency is 1 cycle from the in transfer to out_valid.
  - buf is never full in EMPTY.
- SHIFT state, output transfer with cnt < NCHUNK-1:
  - Shift sh by OUT_BITS toward the emit end.
  - cnt += 1.
- SHIFT state, output transfer with cnt == NCHUNK-1 (last chunk):
  - If buf_full: sh = buf, buf_full = 0, cnt = 0, stay in SHIFT.
  - Else if an input transfer happens the same cycle: sh = in_data, cnt = 0, stay in SHIFT. The word bypasses buf.
  - Else: go to EMPTY.
- SHIFT state, input transfer not consumed by the bypass above: buf = in_data, buf_full = 1.
- Simultaneous input and output transfer when not on the last chunk: the word goes into buf, and the shift proceeds.
- Throughput: one chunk per cycle sustained. A new word's first chunk follows the previous word's last chunk with zero bubble.
- Never accept an input word while buf_full. Never drop or duplicate a chunk.
- in_ready does not depend combinationally on out_ready, and out_valid does not depend combinationally on in_valid.
- No assertion of out_valid may depend on out_ready.

Decomposition:
- Shared package bd_pkg holds:
  - localparams BD_WORD_BITS = 32 and BD_CHUNK_BITS = 8.
  - typedef enum logic {SER_EMPTY, SER_SHIFT} ser_state_t.
  - typedef logic [BD_WORD_BITS-1:0] bd_word_t.
- One natural sub-module: bd_skid_reg, the one-entry ready-valid buffer holding buf/buf_full. It is reusable by future deserializer stages.
- Elaboration-time check: fatal error if IN_BITS % OUT_BITS != 0 or NCHUNK < 2.

Test Plan:
1. Defaults, out_ready held 1, single word 0xA1B2C3D4 → chunks A1, B2, C3, D4 on 4 consecutive cycles; out_last only on D4; first chunk 1 cycle after acceptance.
2. MSB_FIRST=0, same word → chunks D4, C3, B2, A1.
3. Back-to-back source, in_valid held 1 with words 1, 2, 3, out_ready = 1 → 12 chunks with no gap (00,00,00,01,00,00,00,02,...); in_ready never deasserts for more than 3 consecutive cycles; no word lost.
4. Random out_ready (0-5 cycle stalls) and random in_valid, 1000 incrementing words → the scoreboard reassembles every word in order. Out_data and out_last stay stable during each stall. in_ready = 0 whenever buf_full.
5. Buffer full: hold out_ready = 0 and offer words 0x11111111 and 0x22222222 → the first is loaded, the second goes to buf, in_ready = 0. A third word is not accepted until 0x11 is fully emitted.
6. Reset asserted after 2 chunks of 0xDEADBEEF are emitted → out_valid = 0 immediately (asynchronous). After release, in_ready = 1 and the next word 0x01020304 emits 01, 02, 03, 04 with no BE/EF remnants.
